// File: rtl/apb_multi_decode_if.sv
// Bus bundle for the APB decoder: one upstream requester port (s_*) and NUM_SLAVES completer ports (m_*).
// The slave modport is the decoder's view; the master modport is the requester plus completers around it.
interface apb_multi_decode_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic                           s_psel;
  logic                           s_penable;
  logic                           s_pwrite;
  logic [ADDR_W-1:0]              s_paddr;
  logic [DATA_W-1:0]              s_pwdata;
  logic [DATA_W-1:0]              s_prdata;
  logic                           s_pready;
  logic                           s_pslverr;

  logic [NUM_SLAVES-1:0]          m_psel;
  logic                           m_penable;
  logic                           m_pwrite;
  logic [ADDR_W-1:0]              m_paddr;
  logic [DATA_W-1:0]              m_pwdata;
  logic [NUM_SLAVES*DATA_W-1:0]   m_prdata;
  logic [NUM_SLAVES-1:0]          m_pready;
  logic [NUM_SLAVES-1:0]          m_pslverr;

  modport slave (
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    output s_prdata, s_pready, s_pslverr,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    input  m_prdata, m_pready, m_pslverr
  );

  modport master (
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    input  s_prdata, s_pready, s_pslverr,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    output m_prdata, m_pready, m_pslverr
  );
endinterface

// File: rtl/apb_multi_decode.sv
// APB 1-to-N decoder: registers one upstream access, replays it to the decoded completer and
// returns its response; unmapped addresses and wait-state timeouts complete with an error.
module apb_multi_decode #(
  parameter int                          NUM_SLAVES     = 4,
  parameter int                          ADDR_W         = 32,
  parameter int                          DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDR     = {32'h0000_3000, 32'h0000_2000,
                                                           32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_MASK     = {NUM_SLAVES{32'hFFFF_F000}},
  parameter int                          TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  apb_multi_decode_if.slave bus,
  output logic [7:0]        err_cnt,
  output logic              timeout_evt
);

  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d, tcnt_inc;
  logic [IDX_W-1:0]    lat_idx, dec_idx;
  logic                lat_hit, dec_hit;
  logic                sel_ready, sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                accept, enter_access, unmapped, done, abort;

  // Address decode of the live upstream address; only consumed on the accepting IDLE cycle.
  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin : decode
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!dec_hit &&
          ((bus.s_paddr & ADDR_MASK[i*ADDR_W +: ADDR_W]) == BASE_ADDR[i*ADDR_W +: ADDR_W])) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  // Responses of completers other than the latched target never reach the datapath.
  assign sel_ready = bus.m_pready[lat_idx];
  assign sel_err   = bus.m_pslverr[lat_idx];
  assign sel_rdata = bus.m_prdata[lat_idx*DATA_W +: DATA_W];
  assign tcnt_inc  = tcnt_q + TCNT_W'(1);

  always_comb begin : fsm_next
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    accept       = 1'b0;
    enter_access = 1'b0;
    unmapped     = 1'b0;
    done         = 1'b0;
    abort        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.s_psel && !bus.s_penable) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (lat_hit) begin
          enter_access = 1'b1;
          tcnt_d       = '0;
          state_d      = ACCESS;
        end else begin
          unmapped = 1'b1;
          state_d  = RESP;
        end
      end
      ACCESS: begin
        // A ready arriving on the cycle the count would expire still completes normally.
        if (sel_ready) begin
          done    = 1'b1;
          state_d = RESP;
        end else if ((TIMEOUT_CYCLES > 0) && (tcnt_inc == TCNT_W'(TIMEOUT_CYCLES))) begin
          abort   = 1'b1;
          tcnt_d  = tcnt_inc;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs are registered and computed from the transition being taken on this edge.
  // NOTE: state and output registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset clears every control and output flop, including latched address/data, so a
    // mid-transfer reset leaves no stale transfer visible downstream.
    if (rst) begin
      state_q       <= IDLE;
      tcnt_q        <= '0;
      lat_idx       <= '0;
      lat_hit       <= 1'b0;
      bus.s_pready  <= 1'b0;
      bus.s_pslverr <= 1'b0;
      bus.s_prdata  <= '0;
      bus.m_psel    <= '0;
      bus.m_penable <= 1'b0;
      bus.m_pwrite  <= 1'b0;
      bus.m_paddr   <= '0;
      bus.m_pwdata  <= '0;
      err_cnt       <= '0;
      timeout_evt   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      timeout_evt  <= abort;
      bus.s_pready <= unmapped | done | abort;

      if (accept) begin
        lat_idx      <= dec_idx;
        lat_hit      <= dec_hit;
        bus.m_paddr  <= bus.s_paddr;
        bus.m_pwrite <= bus.s_pwrite;
        bus.m_pwdata <= bus.s_pwdata;
        bus.m_psel   <= dec_hit ? (NUM_SLAVES'(1) << dec_idx) : '0;
      end

      if (enter_access) begin
        bus.m_penable <= 1'b1;
      end

      if (done || abort) begin
        bus.m_psel    <= '0;
        bus.m_penable <= 1'b0;
      end

      // Read data is only passed up for clean reads; writes and any error return zero.
      if (unmapped || done || abort) begin
        bus.s_pslverr <= !done || sel_err;
        bus.s_prdata  <= (done && !bus.m_pwrite && !sel_err) ? sel_rdata : '0;
      end else if (state_q == RESP) begin
        bus.s_pslverr <= 1'b0;
        bus.s_prdata  <= '0;
      end

      // Only decoder-generated errors are counted; completer pslverr passes through uncounted.
      if ((unmapped || abort) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb_multi_decode.sv
// Randomized bench for apb_multi_decode: a behavioural completer model plus a transaction-level
// reference that predicts target, latency, error, read data and error count for every access.
module tb_apb_multi_decode;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;
  localparam logic [NS*AW-1:0] OVL_BASE = {32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] err_cnt, err_cnt2;
  logic       timeout_evt, timeout_evt2;

  apb_multi_decode_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();
  apb_multi_decode_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus2 ();

  apb_multi_decode #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_cnt(err_cnt), .timeout_evt(timeout_evt)
  );

  // Second decoder with overlapping regions for slaves 1 and 3; it mirrors the main bus inputs.
  apb_multi_decode #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(OVL_BASE),
                     .TIMEOUT_CYCLES(TO)) dut_ovl (
    .clk(clk), .rst(rst), .bus(bus2), .err_cnt(err_cnt2), .timeout_evt(timeout_evt2)
  );

  assign bus2.s_psel    = bus.s_psel;
  assign bus2.s_penable = bus.s_penable;
  assign bus2.s_pwrite  = bus.s_pwrite;
  assign bus2.s_paddr   = bus.s_paddr;
  assign bus2.s_pwdata  = bus.s_pwdata;
  assign bus2.m_prdata  = bus.m_prdata;
  assign bus2.m_pready  = bus.m_pready;
  assign bus2.m_pslverr = bus.m_pslverr;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ref_err_cnt = 0;
  bit check_overlap = 1'b0;

  int unsigned region_base [NS] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};

  // Completer behaviour: wait count per slave (-1 never ready), read data and error flag.
  int          cur_wait  [NS];
  logic [31:0] cur_rdata [NS];
  logic        cur_err   [NS];
  int          acc_cnt   [NS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_target(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & 32'hFFFF_F000) == region_base[i]) return i;
    end
    return -1;
  endfunction

  // Selected completer counts its access cycles; every other completer drives noise.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (bus.m_psel[i] && bus.m_penable) begin
        bus.m_pready[i]           = (cur_wait[i] >= 0) && (acc_cnt[i] >= cur_wait[i]);
        bus.m_pslverr[i]          = bus.m_pready[i] && cur_err[i];
        bus.m_prdata[i*DW +: DW]  = cur_rdata[i];
        acc_cnt[i]++;
      end else begin
        acc_cnt[i]                = 0;
        bus.m_pready[i]           = 1'($urandom);
        bus.m_pslverr[i]          = 1'($urandom);
        bus.m_prdata[i*DW +: DW]  = $urandom;
      end
    end
  end

  task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input int wt, input logic serr, input logic [31:0] rd);
    int          tgt, lat, cyc;
    logic        to_abort, exp_err;
    logic [31:0] exp_rd;
    logic [NS-1:0] exp_sel;

    tgt = ref_target(a);
    for (int i = 0; i < NS; i++) begin
      cur_wait[i]  = wt;
      cur_rdata[i] = (i == tgt) ? rd : $urandom;
      cur_err[i]   = serr;
    end
    to_abort = (tgt >= 0) && ((wt < 0) || (wt >= TO));
    if (tgt < 0)       lat = 2;
    else if (to_abort) lat = 2 + TO;
    else               lat = 3 + wt;
    exp_err = (tgt < 0) || to_abort || serr;
    exp_rd  = ((tgt >= 0) && !w && !exp_err) ? rd : 32'h0;
    exp_sel = '0;
    if (tgt >= 0) exp_sel[tgt] = 1'b1;
    if (((tgt < 0) || to_abort) && (ref_err_cnt < 255)) ref_err_cnt++;

    @(negedge clk);
    bus.s_psel = 1'b1; bus.s_penable = 1'b0;
    bus.s_paddr = a; bus.s_pwrite = w; bus.s_pwdata = d;
    @(negedge clk);
    check("setup_psel", bus.m_psel, exp_sel);
    check("setup_penable", bus.m_penable, 1'b0);
    if (check_overlap) check("overlap_psel", bus2.m_psel, 4'b0010);
    if (tgt >= 0) begin
      check("setup_paddr", bus.m_paddr, a);
      check("setup_pwrite", bus.m_pwrite, w);
      check("setup_pwdata", bus.m_pwdata, d);
    end
    bus.s_penable = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if ((tgt >= 0) && (cyc == 1)) begin
        check("access_penable", bus.m_penable, 1'b1);
        check("access_psel", bus.m_psel, exp_sel);
      end
      if (!bus.s_pready) begin
        // Upstream wiggles mid-transfer must not disturb the latched access.
        bus.s_paddr  = $urandom;
        bus.s_pwdata = $urandom;
        bus.s_pwrite = 1'($urandom);
      end
    end while (!bus.s_pready && (cyc < lat + 20));
    check("latency", cyc + 1, lat);
    check("pslverr", bus.s_pslverr, exp_err);
    check("prdata", bus.s_prdata, exp_rd);
    check("timeout_evt", timeout_evt, to_abort);
    check("err_cnt", err_cnt, ref_err_cnt);
    check("resp_psel", bus.m_psel, '0);
    check("resp_penable", bus.m_penable, 1'b0);
    if (tgt >= 0) check("resp_paddr", bus.m_paddr, a);
    bus.s_psel = 1'b0; bus.s_penable = 1'b0;
    @(negedge clk);
    check("pready_pulse", bus.s_pready, 1'b0);
    check("evt_pulse", timeout_evt, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          wt;

    bus.s_psel = 1'b0; bus.s_penable = 1'b0; bus.s_pwrite = 1'b0;
    bus.s_paddr = '0;  bus.s_pwdata = '0;
    repeat (3) @(negedge clk);
    check("rst_pready", bus.s_pready, 1'b0);
    check("rst_pslverr", bus.s_pslverr, 1'b0);
    check("rst_prdata", bus.s_prdata, '0);
    check("rst_psel", bus.m_psel, '0);
    check("rst_penable", bus.m_penable, 1'b0);
    check("rst_paddr", bus.m_paddr, '0);
    check("rst_err_cnt", err_cnt, '0);
    check("rst_timeout_evt", timeout_evt, 1'b0);
    rst = 1'b0;

    check_overlap = 1'b1;
    do_xfer(32'h0000_1000, 1'b0, 32'h0, 0, 1'b0, 32'h1234_5678);
    check_overlap = 1'b0;

    do_xfer(32'h0000_2004, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h0);
    do_xfer(32'h0000_1010, 1'b0, 32'h0, 5, 1'b0, 32'hDEAD_BEEF);
    do_xfer(32'h0000_8000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    do_xfer(32'h0000_3008, 1'b0, 32'h0, TO - 1, 1'b0, 32'hCAFE_F00D);
    do_xfer(32'h0000_0ffc, 1'b0, 32'h0, 1, 1'b1, 32'h5555_AAAA);

    repeat (150) begin
      if ($urandom_range(0, 4) == 0) a = ($urandom_range(4, 32'h000F_FFFF) << 12) | ($urandom & 32'hFFC);
      else                           a = ($urandom_range(0, 3) << 12) | ($urandom & 32'hFFC);
      wt = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 6));
      do_xfer(a, 1'($urandom), $urandom, wt, ($urandom_range(0, 3) == 0), $urandom);
    end

    // Reset in the middle of an ACCESS to slave 0.
    for (int i = 0; i < NS; i++) cur_wait[i] = -1;
    @(negedge clk);
    bus.s_psel = 1'b1; bus.s_penable = 1'b0; bus.s_paddr = 32'h0; bus.s_pwrite = 1'b1;
    @(negedge clk);
    bus.s_penable = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_access_penable", bus.m_penable, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_psel", bus.m_psel, '0);
    check("midrst_penable", bus.m_penable, 1'b0);
    check("midrst_pready", bus.s_pready, 1'b0);
    check("midrst_err_cnt", err_cnt, '0);
    check("midrst_pwrite", bus.m_pwrite, 1'b0);
    ref_err_cnt = 0;
    bus.s_psel = 1'b0; bus.s_penable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    do_xfer(32'h0000_0000, 1'b0, 32'h0, 2, 1'b0, 32'h0BAD_F00D);

    repeat (300) begin
      do_xfer(32'h0000_3000 | ($urandom & 32'hFFC), 1'($urandom), $urandom, -1, 1'b0, $urandom);
    end
    check("err_cnt_sat", err_cnt, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_multi_decode.md
APB_MULTI_DECODE -- requirements
Module: apb_multi_decode

Interface
REQ-001 Parameter NUM_SLAVES, default 4: number of completer ports, legal range 1-16.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Parameter BASE_ADDR, default {0x3000,0x2000,0x1000,0x0000}: packed NUM_SLAVES*ADDR_W region bases, slave 0 in LSBs.
REQ-005 Parameter ADDR_MASK, default all 0xFFFF_F000: packed NUM_SLAVES*ADDR_W compare masks.
REQ-006 Parameter TIMEOUT_CYCLES, default 64: max wait-state cycles per access; 0 disables timeout.
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 clk  in  1  sole clock, all state updates on rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 s_psel, s_penable, s_pwrite  in  1 each  upstream APB requester controls.
REQ-011 s_paddr  in  ADDR_W  upstream address.
REQ-012 s_pwdata  in  DATA_W  upstream write data.
REQ-013 s_prdata  out  DATA_W  upstream read data.
REQ-014 s_pready, s_pslverr  out  1 each  upstream completion and error.
REQ-015 m_psel  out  NUM_SLAVES  one-hot downstream select.
REQ-016 m_penable, m_pwrite  out  1 each  shared downstream controls.
REQ-017 m_paddr  out  ADDR_W; m_pwdata  out  DATA_W  shared downstream address/data.
REQ-018 m_prdata  in  NUM_SLAVES*DATA_W  per-slave read data, slave 0 in LSBs.
REQ-019 m_pready, m_pslverr  in  NUM_SLAVES each  per-slave completion and error.
REQ-020 err_cnt  out  8  saturating count of error completions (unmapped or timeout).
REQ-021 timeout_evt  out  1  one-cycle pulse when an access is aborted by timeout.

Function
REQ-022 All outputs SHALL be registered; FSM states IDLE, SETUP, ACCESS, RESP.
REQ-023 Slave i SHALL hit when (s_paddr & ADDR_MASK[i]) == BASE_ADDR[i]; on multiple hits, lowest index wins.
REQ-024 IDLE: when s_psel=1 and s_penable=0 sampled, SHALL latch address, write flag, wdata, decoded index; go SETUP.
REQ-025 SETUP, hit: SHALL drive m_psel[idx]=1, m_penable=0, latched m_paddr/m_pwrite/m_pwdata for one cycle; go ACCESS.
REQ-026 SETUP, no hit: SHALL keep m_psel=0 and go RESP with error flag set, read data 0.
REQ-027 ACCESS: SHALL drive m_penable=1, hold m_psel; when m_pready[idx]=1 sampled, capture m_prdata[idx] and m_pslverr[idx], drop m_psel/m_penable next cycle, go RESP.
REQ-028 RESP: SHALL assert s_pready=1 for exactly one cycle with captured s_prdata/s_pslverr, then go IDLE; s_prdata SHALL be 0 for writes and errors.
REQ-029 Latency: zero-wait slave gives s_pready 3 cycles after upstream setup; unmapped gives s_pready 2 cycles after setup.
REQ-030 Timeout counter SHALL clear on entering ACCESS and increment each ACCESS cycle without m_pready[idx]; reaching TIMEOUT_CYCLES SHALL abort: m_psel/m_penable low next cycle, RESP with s_pslverr=1, s_prdata=0, timeout_evt=1 for one cycle.
REQ-031 m_pready on the same cycle the count reaches TIMEOUT_CYCLES SHALL complete normally (ready wins).
REQ-032 err_cnt SHALL increment by 1 at each RESP with error from unmapped or timeout (not slave pslverr), saturating at 255.
REQ-033 Upstream signal changes after SETUP latch SHALL be ignored until return to IDLE; a new setup is accepted only in IDLE.
REQ-034 m_pready/m_pslverr/m_prdata of unselected slaves SHALL be ignored.

Reset
REQ-035 rst=1 at any edge, including mid-transfer, SHALL force IDLE; s_pready, s_pslverr, s_prdata, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, err_cnt, timeout_evt, timeout counter to 0 on that edge.

Verification
REQ-036 Write 0x2004 data 0xA5A5_0001, slave 2 zero-wait -> m_psel=0b0100, m_paddr=0x2004; s_pready T+3, s_pslverr=0.
REQ-037 Read 0x1010, slave 1 asserts pready after 5 wait cycles with 0xDEAD_BEEF -> s_prdata=0xDEAD_BEEF, s_pready T+8.
REQ-038 Read 0x8000 (unmapped) -> m_psel stays 0, s_pready T+2, s_pslverr=1, s_prdata=0, err_cnt 0->1.
REQ-039 TIMEOUT_CYCLES=64, slave 3 never ready -> abort after 64 ACCESS cycles, timeout_evt one pulse, s_pslverr=1; 300 such aborts -> err_cnt=255.
REQ-040 rst asserted during ACCESS of slave 0 -> next edge m_psel=0, m_penable=0, s_pready=0; subsequent access to 0x0000 completes normally.
REQ-041 Overlap: BASE_ADDR[1]=BASE_ADDR[3]=0x1000, access 0x1000 -> m_psel=0b0010 only.
